// File: rtl/mult_div_engine.sv
// mult_div_engine: 32-bit MULT/MULTU/DIV/DIVU unit, radix-2 iterative (33-cycle latency); define MULT_DIV_FAST_MULT_EN for single-cycle multiplies
module mult_div_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        exe_wr,
    output logic        busy,
    output logic        res_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q;
    logic [1:0]  op_q;
    logic [5:0]  cnt_q;
    logic [31:0] x_q, rem_q, quo_q, a_raw_q, hi_q, lo_q;
    logic        neg_p_q, neg_r_q;
    logic        sa, sb;
    logic [31:0] mag_a, mag_b, rem_d, quo_d, q_s, r_s, fin_hi, fin_lo;
    logic [32:0] trial, sum;
    logic [63:0] p_s;
    // sign and magnitude of the incoming operands (op[0]=0 means signed)
    always_comb begin
        sa = ~op[0] & src_a[31];
        sb = ~op[0] & src_b[31];
        mag_a = sa ? -src_a : src_a;
        mag_b = sb ? -src_b : src_b;
    end
    // one radix-2 step: restoring divide (rem:quo shift left) or shift-add multiply (acc:multiplier shift right), plus final sign and zero-divisor fixup
    always_comb begin
        trial = {rem_q, quo_q[31]} - {1'b0, x_q};
        sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, x_q} : 33'd0);
        rem_d = op_q[1] ? (trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0]) : sum[32:1];
        quo_d = op_q[1] ? {quo_q[30:0], ~trial[32]} : {sum[0], quo_q[31:1]};
        p_s = neg_p_q ? -{rem_d, quo_d} : {rem_d, quo_d};
        q_s = neg_p_q ? -quo_d : quo_d;
        r_s = neg_r_q ? -rem_d : rem_d;
        fin_hi = op_q[1] ? ((x_q == 32'd0) ? a_raw_q : r_s) : p_s[63:32];
        fin_lo = op_q[1] ? ((x_q == 32'd0) ? 32'hFFFF_FFFF : q_s) : p_s[31:0];
    end
`ifdef MULT_DIV_FAST_MULT_EN
    logic [63:0] prod_fast;
    // full-width product of sign-extended operands gives both signed and unsigned results
    always_comb prod_fast = {{32{sa}}, src_a} * {{32{sb}}, src_b};
`endif
    // control FSM and datapath registers; rst beats flush, flush beats start/exe_wr
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            op_q    <= 2'd0;
            x_q     <= 32'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            a_raw_q <= 32'd0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_q    <= op;
                    cnt_q   <= 6'd0;
                    rem_q   <= 32'd0;
                    quo_q   <= op[1] ? mag_a : mag_b;
                    x_q     <= op[1] ? mag_b : mag_a;
                    a_raw_q <= src_a;
                    neg_p_q <= sa ^ sb;
                    neg_r_q <= sa;
`ifdef MULT_DIV_FAST_MULT_EN
                    if (!op[1]) begin
                        state_q <= DONE;
                        hi_q    <= prod_fast[63:32];
                        lo_q    <= prod_fast[31:0];
                    end else begin
                        state_q <= CALC;
                    end
`else
                    state_q <= CALC;
`endif
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_q <= DONE;
                        hi_q    <= fin_hi;
                        lo_q    <= fin_lo;
                    end
                end
                DONE: if (exe_wr) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy      = ((state_q == IDLE) & start & ~flush) | ((state_q == CALC) & ~flush);
    assign res_valid = (state_q == DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_mult_div_engine.sv
// tb_mult_div_engine: directed self-checking bench for mult_div_engine
module tb_mult_div_engine;
    logic        clk = 1'b0;
    logic        rst, start, flush, exe_wr;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, res_valid;
    logic [31:0] hi, lo;
    int          errs = 0;
    int          checks = 0;

`ifdef MULT_DIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    mult_div_engine dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .exe_wr(exe_wr), .busy(busy), .res_valid(res_valid), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Launch one op at the next negedge (cycle 0) and step until res_valid; returns latency, result and whether busy matched each cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] h, output logic [31:0] l, output logic busy_ok);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0; exe_wr = 1'b0;
        #1;
        busy_ok = busy;
        lat = -1; h = 32'hx; l = 32'hx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (res_valid) begin
                lat = c; h = hi; l = lo;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    // Retire the result in DONE and return to the cycle after (IDLE).
    task automatic consume();
        exe_wr = 1'b1;
        @(negedge clk);
        exe_wr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; exe_wr = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        checks++; if (hi !== 32'd0) begin errs++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0) begin errs++; $display("FAIL reset_lo got=%h exp=0", lo); end
        rst = 1'b0;
    endtask

    task automatic test_divu();
        int lat; logic [31:0] h, l; logic bok;
        run_op(2'd3, 32'd100, 32'd7, lat, h, l, bok);
        checks++; if (lat !== 33) begin errs++; $display("FAIL divu_lat got=%0d exp=33", lat); end
        checks++; if (bok !== 1'b1) begin errs++; $display("FAIL divu_busy got=%b exp=1", bok); end
        checks++; if (l !== 32'd14) begin errs++; $display("FAIL divu_lo got=%h exp=0000000e", l); end
        checks++; if (h !== 32'd2) begin errs++; $display("FAIL divu_hi got=%h exp=00000002", h); end
        consume();
        checks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL divu_retire got=%b exp=0", res_valid); end
        run_op(2'd3, 32'd7, 32'd100, lat, h, l, bok);
        checks++; if ({h, l} !== {32'd7, 32'd0}) begin errs++; $display("FAIL divu_small got=%h_%h exp=00000007_00000000", h, l); end
        consume();
        run_op(2'd3, 32'hFFFF_FFFF, 32'd1, lat, h, l, bok);
        checks++; if ({h, l} !== {32'd0, 32'hFFFF_FFFF}) begin errs++; $display("FAIL divu_max got=%h_%h exp=00000000_ffffffff", h, l); end
        consume();
    endtask

    task automatic test_div_signed();
        int lat; logic [31:0] h, l; logic bok;
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, lat, h, l, bok);
        checks++; if ({h, l} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errs++; $display("FAIL div_neg7_2 got=%h_%h exp=ffffffff_fffffffd", h, l); end
        checks++; if (lat !== 33) begin errs++; $display("FAIL div_lat got=%0d exp=33", lat); end
        consume();
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, h, l, bok);
        checks++; if ({h, l} !== {32'd0, 32'h8000_0000}) begin errs++; $display("FAIL div_min_m1 got=%h_%h exp=00000000_80000000", h, l); end
        consume();
        run_op(2'd2, 32'd7, 32'hFFFF_FFFE, lat, h, l, bok);
        checks++; if ({h, l} !== {32'd1, 32'hFFFF_FFFD}) begin errs++; $display("FAIL div_7_neg2 got=%h_%h exp=00000001_fffffffd", h, l); end
        consume();
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] h, l; logic bok;
        run_op(2'd3, 32'd5, 32'd0, lat, h, l, bok);
        checks++; if ({h, l} !== {32'd5, 32'hFFFF_FFFF}) begin errs++; $display("FAIL divu_zero got=%h_%h exp=00000005_ffffffff", h, l); end
        checks++; if (lat !== 33) begin errs++; $display("FAIL divu_zero_lat got=%0d exp=33", lat); end
        consume();
        run_op(2'd2, 32'hFFFF_FFFB, 32'd0, lat, h, l, bok);
        checks++; if ({h, l} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin errs++; $display("FAIL div_zero got=%h_%h exp=fffffffb_ffffffff", h, l); end
        consume();
    endtask

    task automatic test_mult();
        int lat; logic [31:0] h, l; logic bok;
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, lat, h, l, bok);
        checks++; if ({h, l} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin errs++; $display("FAIL mult_neg3_5 got=%h_%h exp=ffffffff_fffffff1", h, l); end
        checks++; if (lat !== MUL_LAT) begin errs++; $display("FAIL mult_lat got=%0d exp=%0d", lat, MUL_LAT); end
        checks++; if (bok !== 1'b1) begin errs++; $display("FAIL mult_busy got=%b exp=1", bok); end
        consume();
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, h, l, bok);
        checks++; if ({h, l} !== {32'hFFFF_FFFE, 32'h0000_0001}) begin errs++; $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", h, l); end
        consume();
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, lat, h, l, bok);
        checks++; if ({h, l} !== {32'h4000_0000, 32'd0}) begin errs++; $display("FAIL mult_min_sq got=%h_%h exp=40000000_00000000", h, l); end
        consume();
    endtask

    task automatic test_flush();
        int lat; logic [31:0] h, l; logic bok, seen_valid;
        seen_valid = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'd3; src_a = 32'd1000; src_b = 32'd3; exe_wr = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            #1;
            if (res_valid) seen_valid = 1'b1;
        end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_busy_same got=%b exp=0", busy); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_busy_next got=%b exp=0", busy); end
        checks++; if ((seen_valid | res_valid) !== 1'b0) begin errs++; $display("FAIL flush_valid got=%b exp=0", seen_valid | res_valid); end
        run_op(2'd3, 32'd100, 32'd7, lat, h, l, bok);
        checks++; if ({lat, h, l} !== {32'd33, 32'd2, 32'd14}) begin errs++; $display("FAIL flush_next_op got=lat%0d %h_%h exp=lat33 00000002_0000000e", lat, h, l); end
        checks++; if (bok !== 1'b1) begin errs++; $display("FAIL flush_next_busy got=%b exp=1", bok); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errs++; $display("FAIL flush_done got=%b exp=0", res_valid); end
    endtask

    task automatic test_done_hold();
        int lat; logic [31:0] h, l; logic bok;
        run_op(2'd1, 32'h0001_0000, 32'h0001_0000, lat, h, l, bok);
        checks++; if ({h, l} !== {32'd1, 32'd0}) begin errs++; $display("FAIL hold_result got=%h_%h exp=00000001_00000000", h, l); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = 1'b1; op = 2'd3; src_a = 32'd9; src_b = 32'd2; exe_wr = 1'b0;
            #1;
            checks++; if ({res_valid, busy} !== 2'b10) begin errs++; $display("FAIL hold_flags c=%0d got=%b%b exp=10", c, res_valid, busy); end
            checks++; if ({hi, lo} !== {32'd1, 32'd0}) begin errs++; $display("FAIL hold_hilo c=%0d got=%h_%h exp=00000001_00000000", c, hi, lo); end
        end
        start = 1'b0;
        consume();
        checks++; if ({res_valid, busy} !== 2'b00) begin errs++; $display("FAIL hold_release got=%b%b exp=00", res_valid, busy); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] h, l; logic bok;
        @(negedge clk);
        start = 1'b1; op = 2'd3; src_a = 32'd50; src_b = 32'd5;
        repeat (5) begin @(negedge clk); start = 1'b0; end
        rst = 1'b1; flush = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; start = 1'b0;
        #1;
        checks++; if ({busy, res_valid, hi, lo} !== 66'd0) begin errs++; $display("FAIL reset_calc got=%b%b %h_%h exp=00 00000000_00000000", busy, res_valid, hi, lo); end
        run_op(2'd3, 32'd9, 32'd2, lat, h, l, bok);
        checks++; if ({h, l} !== {32'd1, 32'd4}) begin errs++; $display("FAIL reset_after got=%h_%h exp=00000001_00000004", h, l); end
        rst = 1'b1; exe_wr = 1'b1;
        @(negedge clk);
        rst = 1'b0; exe_wr = 1'b0;
        #1;
        checks++; if ({res_valid, hi, lo} !== 65'd0) begin errs++; $display("FAIL reset_done got=%b %h_%h exp=0 00000000_00000000", res_valid, hi, lo); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] h, l; logic bok;
        run_op(2'd1, 32'd6, 32'd7, lat, h, l, bok);
        checks++; if ({h, l} !== {32'd0, 32'd42}) begin errs++; $display("FAIL b2b_first got=%h_%h exp=00000000_0000002a", h, l); end
        consume();
        run_op(2'd3, 32'd42, 32'd6, lat, h, l, bok);
        checks++; if ({lat, h, l} !== {32'd33, 32'd0, 32'd7}) begin errs++; $display("FAIL b2b_second got=lat%0d %h_%h exp=lat33 00000000_00000007", lat, h, l); end
        consume();
    endtask

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_div_zero();
        test_mult();
        test_flush();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_engine.md
MULT_DIV_ENGINE -- requirements
Module: mult_div_engine

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: start  in  1  EXE stage holds a MULT/MULTU/DIV/DIVU instruction.
REQ-004 SHALL have port: op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-005 SHALL have port: src_a  in  32  rs operand (dividend/multiplicand).
REQ-006 SHALL have port: src_b  in  32  rt operand (divisor/multiplier).
REQ-007 SHALL have port: flush  in  1  exception flush of the EXE stage; cancels any operation.
REQ-008 SHALL have port: exe_wr  in  1  EXE stage advances this cycle (result consumed).
REQ-009 SHALL have port: busy  out  1  stall request to hazard/flush control (DIVMULTBusy).
REQ-010 SHALL have port: res_valid  out  1  hi/lo hold a valid result.
REQ-011 SHALL have port: hi  out  32  HI result (product high word / remainder).
REQ-012 SHALL have port: lo  out  32  LO result (product low word / quotient).

Function
REQ-013 SHALL implement states IDLE, CALC, DONE.
REQ-014 SHALL accept an operation in IDLE when start=1 and flush=0, latching op, |src_a|, |src_b| and sign bits; cycle of acceptance = cycle 0.
REQ-015 SHALL drive busy combinationally = (IDLE and start and !flush) or (CALC and !flush); busy=0 in DONE.
REQ-016 SHALL, in CALC, run 32 radix-2 iterations (restoring divide / shift-add multiply) using a 6-bit counter; CALC occupies cycles 1..32, DONE entered at cycle 33.
REQ-017 SHALL, in DONE, assert res_valid=1 with stable hi/lo; return to IDLE on the first cycle exe_wr=1; hold DONE while exe_wr=0 (cache stall).
REQ-018 SHALL NOT re-accept start in DONE; a new operation is accepted only from IDLE.
REQ-019 SHALL for signed ops compute on magnitudes then negate: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
REQ-020 SHALL for DIV 0x80000000 / 0xFFFFFFFF produce lo=0x80000000, hi=0x00000000.
REQ-021 SHALL for divide by zero (any signedness) produce lo=0xFFFFFFFF, hi=src_a as latched, with normal 33-cycle latency.
REQ-022 SHALL on flush=1 in any state go to IDLE next cycle, drop res_valid, and discard partial results; flush has priority over start and exe_wr.
REQ-023 SHALL keep hi/lo unchanged outside DONE except during CALC internal updates; res_valid=0 outside DONE.

Reset
REQ-024 SHALL on rst=1 at a clock edge enter IDLE, clear counter, set hi=0, lo=0, res_valid=0; busy=0 from the following cycle.
REQ-025 SHALL give rst priority over flush, start and exe_wr, including mid-CALC and in DONE.

Configuration
REQ-026 SHALL support macro MULT_DIV_FAST_MULT_EN.
REQ-027 SHALL, with MULT_DIV_FAST_MULT_EN defined, compute MULT/MULTU in one cycle: IDLE -> DONE at cycle 1, busy high only in cycle 0; divides unchanged.
REQ-028 SHALL, without MULT_DIV_FAST_MULT_EN, compute MULT/MULTU iteratively with the same 33-cycle latency as divides.

Verification
REQ-029 SHALL cover: DIVU 100/7, exe_wr=1 -> busy cycles 0..32, cycle 33 res_valid=1, lo=14, hi=2, busy=0.
REQ-030 SHALL cover: DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-031 SHALL cover: MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; latency 33 cycles without macro, 1 cycle with MULT_DIV_FAST_MULT_EN.
REQ-032 SHALL cover: DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
REQ-033 SHALL cover: flush at cycle 10 of DIVU -> next cycle IDLE, busy=0, res_valid never asserted; new op accepted the cycle after.
REQ-034 SHALL cover: exe_wr=0 for 5 cycles in DONE -> res_valid and hi/lo held, busy=0, start ignored; exe_wr=1 -> IDLE next cycle.
